// File: rtl/cross_bar_mux_arbiter.sv
// Crossbar output stage: packet-granular round-robin merge of SOURCE_NO streams, beats tagged with source index.
// Latency 1 cycle from accept to m_axis (1 arbitration bubble per packet); a 2-entry skid absorbs m_axis_tready stalls.
module cross_bar_mux_arbiter #(
  parameter int SSEL_WIDTH = 2,
  parameter int SOURCE_NO  = 2**SSEL_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [SOURCE_NO-1:0][DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [SOURCE_NO-1:0]                s_axis_tvalid,
  input  logic [SOURCE_NO-1:0]                s_axis_tlast,
  output logic [SOURCE_NO-1:0]                s_axis_tready,
  output logic [DATA_WIDTH-1:0]               m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic [SSEL_WIDTH-1:0]               m_axis_tsrc,
  input  logic                                m_axis_tready
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic                  last;
    logic [SSEL_WIDTH-1:0] src;
  } beat_t;

  state_t                state, state_nxt;
  logic [SSEL_WIDTH-1:0] grant, grant_nxt;
  logic [SSEL_WIDTH-1:0] last_grant, last_grant_nxt;
  logic [SSEL_WIDTH-1:0] rr_idx, rr_pick;
  logic                  rr_hit;

  beat_t                 main_q, skid_q, beat_in;
  logic                  main_vld, skid_vld, skid_ready;
  logic                  push, pop, skid_vld_nxt;

  // Search starts just after the last winner; index overflow gives the modulo wrap.
  always_comb begin
    rr_hit  = 1'b0;
    rr_pick = last_grant;
    rr_idx  = '0;
    for (int i = 1; i <= SOURCE_NO; i++) begin
      rr_idx = last_grant + SSEL_WIDTH'(i);
      if (!rr_hit && s_axis_tvalid[rr_idx]) begin
        rr_hit  = 1'b1;
        rr_pick = rr_idx;
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < SOURCE_NO; i++) begin
      if (state == ACTIVE && grant == SSEL_WIDTH'(i)) begin
        s_axis_tready[i] = skid_ready;
      end
    end
  end

  always_comb begin
    push         = (state == ACTIVE) && s_axis_tvalid[grant] && skid_ready;
    pop          = main_vld && m_axis_tready;
    beat_in.dat  = s_axis_tdata[grant];
    beat_in.last = s_axis_tlast[grant];
    beat_in.src  = grant;
    skid_vld_nxt = skid_vld ? !pop : (main_vld && !pop && push);
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (rr_hit) begin
          grant_nxt = rr_pick;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (push && s_axis_tlast[grant]) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SSEL_WIDTH'(SOURCE_NO - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Skid only fills while main is held; it always drains into main first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      skid_ready <= 1'b1;
    end else begin
      if (!main_vld || pop) begin
        if (skid_vld) begin
          main_q   <= skid_q;
          main_vld <= 1'b1;
        end else if (push) begin
          main_q   <= beat_in;
          main_vld <= 1'b1;
        end else begin
          main_vld <= 1'b0;
        end
      end else if (push) begin
        skid_q <= beat_in;
      end
      skid_vld   <= skid_vld_nxt;
      skid_ready <= !skid_vld_nxt;
    end
  end

  assign m_axis_tvalid = main_vld;
  assign m_axis_tdata  = main_q.dat;
  assign m_axis_tlast  = main_q.last;
  assign m_axis_tsrc   = main_q.src;

endmodule

// File: tb/tb_cross_bar_mux_arbiter.sv
// Bench for cross_bar_mux_arbiter: per-source stimulus queues feed a scoreboard filled on input accept, drained on output.
module tb_cross_bar_mux_arbiter;

  localparam int SW = 2;
  localparam int SN = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
    logic [SW-1:0] src;
  } tb_beat_t;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic [SN-1:0][DW-1:0] s_axis_tdata;
  logic [SN-1:0]        s_axis_tvalid;
  logic [SN-1:0]        s_axis_tlast;
  logic [SN-1:0]        s_axis_tready;
  logic [DW-1:0]        m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic [SW-1:0]        m_axis_tsrc;
  logic                 m_axis_tready;

  cross_bar_mux_arbiter #(.SSEL_WIDTH(SW), .SOURCE_NO(SN), .DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tsrc   (m_axis_tsrc),
    .m_axis_tready (m_axis_tready)
  );

  tb_beat_t src_q [SN][$];
  tb_beat_t exp_q [$];
  logic     rdy_q [$];
  int       got_src [$];
  int       xfer_cyc [$];
  logic [SN-1:0] hold;
  int       acc_cnt [SN];
  int       cyc, n_chk, n_bad, occ, full_seen;
  int       in_acc, out_acc;
  logic     prev_vld, prev_rdy;
  tb_beat_t prev_beat, cur_beat, e;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge aclk);
      #1;
    end
  endtask

  task automatic clr_tb();
    exp_q.delete();
    rdy_q.delete();
    got_src.delete();
    xfer_cyc.delete();
    for (int i = 0; i < SN; i++) begin
      src_q[i].delete();
      acc_cnt[i] = 0;
    end
    hold      = '0;
    full_seen = 0;
  endtask

  task automatic push_pkt(input int s, input int n, input logic [DW-1:0] base);
    tb_beat_t b;
    for (int k = 0; k < n; k++) begin
      b.dat  = base + DW'(k);
      b.last = (k == n - 1);
      b.src  = SW'(s);
      src_q[s].push_back(b);
    end
  endtask

  function automatic int pending();
    int p = exp_q.size() + int'(m_axis_tvalid);
    for (int i = 0; i < SN; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic wait_drain(input string tag, input int lim);
    int k = 0;
    while (pending() > 0 && k < lim) begin
      step(1);
      k++;
    end
    chk_eq(tag, 64'(pending()), 64'd0);
  endtask

  task automatic wait_acc(input string tag, input int s, input int n);
    int k = 0;
    while (acc_cnt[s] < n && k < 50) begin
      step(1);
      k++;
    end
    chk_eq(tag, 64'(acc_cnt[s]), 64'(n));
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    clr_tb();
    step(2);
    aresetn = 1'b1;
    step(1);
  endtask

  initial forever #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Input driver: updates just after each rising edge.
  initial forever begin
    @(posedge aclk);
    #1;
    for (int i = 0; i < SN; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i]  = src_q[i][0].dat;
        s_axis_tlast[i]  = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i] = 1'b0;
      end
    end
    m_axis_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
  end

  // Monitor on the falling edge: records handshakes that complete at the next rising edge.
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      occ      = 0;
      prev_vld = 1'b0;
    end else begin
      in_acc = 0;
      for (int i = 0; i < SN; i++) begin
        if (s_axis_tvalid[i] && s_axis_tready[i] && src_q[i].size() > 0) begin
          in_acc++;
          acc_cnt[i]++;
          exp_q.push_back(src_q[i].pop_front());
        end
      end
      chk_eq("rdy_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
      chk_eq("occ_vld", 64'(m_axis_tvalid), 64'(occ > 0));
      if (occ == 2) begin
        full_seen++;
        chk_eq("full_rdy", 64'(s_axis_tready), 64'd0);
      end
      cur_beat.dat  = m_axis_tdata;
      cur_beat.last = m_axis_tlast;
      cur_beat.src  = m_axis_tsrc;
      if (prev_vld && !prev_rdy) begin
        chk_eq("stall_vld", 64'(m_axis_tvalid), 64'd1);
        chk_eq("stall_beat", 64'(cur_beat), 64'(prev_beat));
      end
      out_acc = int'(m_axis_tvalid && m_axis_tready);
      if (out_acc == 1) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk_eq("beat", 64'(cur_beat), 64'(e));
        end
        got_src.push_back(int'(m_axis_tsrc));
        xfer_cyc.push_back(cyc);
      end
      occ       = occ + in_acc - out_acc;
      prev_vld  = m_axis_tvalid;
      prev_rdy  = m_axis_tready;
      prev_beat = cur_beat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, pending=%0d", pending());
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int exp_rr [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
    int exp_gap [5] = '{3, 3, 3, 0, 0};
    aresetn       = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    n_chk = 0;
    n_bad = 0;
    cyc   = 0;
    occ   = 0;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    clr_tb();
    step(2);

    chk_eq("rst_vld", 64'(m_axis_tvalid), 64'd0);
    chk_eq("rst_dat", 64'(m_axis_tdata), 64'd0);
    chk_eq("rst_last", 64'(m_axis_tlast), 64'd0);
    chk_eq("rst_src", 64'(m_axis_tsrc), 64'd0);
    chk_eq("rst_rdy", 64'(s_axis_tready), 64'd0);
    aresetn = 1'b1;
    step(2);

    // Single 3-beat packet on source 2.
    c0 = cyc;
    push_pkt(2, 3, 32'hA0);
    wait_drain("t1_drain", 50);
    chk_eq("t1_n", 64'(xfer_cyc.size()), 64'd3);
    chk_eq("t1_lat", 64'(xfer_cyc[0] - c0), 64'd3);
    chk_eq("t1_b2", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
    chk_eq("t1_b3", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);

    // All sources offering 2-beat packets: round robin from source 0.
    apply_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < SN; s++)
        push_pkt(s, 2, 32'h100 + 32'(s * 16 + p * 8));
    wait_drain("t2_drain", 200);
    chk_eq("t2_n", 64'(got_src.size()), 64'd16);
    for (int k = 0; k < 16; k++) chk_eq($sformatf("t2_src%0d", k), 64'(got_src[k]), 64'(exp_rr[k]));
    for (int k = 1; k < 16; k++)
      chk_eq($sformatf("t2_gap%0d", k), 64'(xfer_cyc[k] - xfer_cyc[k-1]), (k % 2 == 1) ? 64'd1 : 64'd2);

    // Backpressure on a 4-beat packet from source 1.
    clr_tb();
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    push_pkt(1, 4, 32'hB0);
    wait_drain("t3_drain", 80);
    chk_eq("t3_n", 64'(xfer_cyc.size()), 64'd4);
    chk_eq("t3_full_seen", 64'(full_seen > 0), 64'd1);

    // Source 3 stalls mid-packet while source 0 waits.
    clr_tb();
    push_pkt(3, 3, 32'hC0);
    wait_acc("t4_first", 3, 1);
    hold[3] = 1'b1;
    push_pkt(0, 2, 32'hD0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk_eq("t4_rdy0", 64'(s_axis_tready[0]), 64'd0);
      chk_eq("t4_rdy3", 64'(s_axis_tready[3]), 64'd1);
    end
    hold[3] = 1'b0;
    wait_drain("t4_drain", 80);
    chk_eq("t4_n", 64'(got_src.size()), 64'd5);
    for (int k = 0; k < 5; k++) chk_eq($sformatf("t4_src%0d", k), 64'(got_src[k]), 64'(exp_gap[k]));

    // Back-to-back single-beat packets on source 0.
    clr_tb();
    for (int k = 0; k < 4; k++) push_pkt(0, 1, 32'hE0 + 32'(k));
    wait_drain("t5_drain", 80);
    chk_eq("t5_n", 64'(xfer_cyc.size()), 64'd4);
    for (int k = 1; k < 4; k++) chk_eq($sformatf("t5_gap%0d", k), 64'(xfer_cyc[k] - xfer_cyc[k-1]), 64'd2);

    // Asynchronous reset while a 4-beat packet is in flight.
    clr_tb();
    push_pkt(1, 4, 32'hF0);
    wait_acc("t6_b2", 1, 2);
    @(posedge aclk);
    #2;
    chk_eq("t6_pre_vld", 64'(m_axis_tvalid), 64'd1);
    #1;
    aresetn = 1'b0;
    #1;
    chk_eq("t6_vld", 64'(m_axis_tvalid), 64'd0);
    chk_eq("t6_rdy", 64'(s_axis_tready), 64'd0);
    chk_eq("t6_dat", 64'(m_axis_tdata), 64'd0);
    clr_tb();
    step(2);
    aresetn = 1'b1;
    step(1);
    push_pkt(1, 1, 32'h11);
    push_pkt(3, 1, 32'h33);
    wait_drain("t6_drain", 50);
    chk_eq("t6_n", 64'(got_src.size()), 64'd2);
    chk_eq("t6_first", 64'(got_src[0]), 64'd1);
    chk_eq("t6_second", 64'(got_src[1]), 64'd3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
